// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Package   : serial_frame_pkg
// Purpose   : Shared types and constants for the serial frame deserializer.
// Revision  : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // Line level while no frame is in flight, and the required stop-bit level.
  localparam logic IDLE_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_frame_deserializer_if.sv
`default_nettype none
// ============================================================================
// Interface : serial_frame_deserializer_if
// Purpose   : Serial input, consumer handshake and status bundle.
// Revision  : 1.0 - initial release
// ============================================================================
interface serial_frame_deserializer_if
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              serial_in;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  // Upstream source / downstream consumer side.
  modport master (
    output serial_in, data_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
  );

  // Deserializer side.
  modport slave (
    input  serial_in, data_ready,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/frame_out_buffer.sv
`default_nettype none
// ============================================================================
// Module    : frame_out_buffer
// Purpose   : One-word output holding register with valid/ready handshake.
//             A new word is loaded when the buffer is empty or being drained
//             on the same edge; otherwise it is dropped and overrun pulses.
// Revision  : 1.0 - initial release
// ============================================================================
module frame_out_buffer
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  // Handshake register: deliver, drop with overrun, or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!data_valid || ready) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module    : serial_frame_deserializer
// Purpose   : Receives start / DATA_W data (LSB first) / even parity / stop
//             frames, one bit per clock, and hands good words to a one-word
//             output buffer. Bad parity or stop bit discards the frame.
// Revision  : 1.0 - initial release
// ============================================================================
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  serial_frame_deserializer_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_mismatch;
  logic              stop_edge;
  logic              stop_ok;
  logic              good_frame;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; STOP always returns to IDLE so a new start bit can
  // follow on the very next edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.serial_in != IDLE_LEVEL) state_nxt = DATA;
      DATA:    if (bit_cnt == LAST_BIT)         state_nxt = PARITY;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame verdict, evaluated on the edge that samples the stop bit.
  always_comb begin
    stop_edge  = (state == STOP);
    stop_ok    = (bus.serial_in == STOP_LEVEL);
    good_frame = stop_edge && stop_ok && !par_mismatch;
  end

  // Bit counter, shift register, parity check and error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt        <= '0;
      shreg          <= '0;
      par_mismatch   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg[bit_cnt] <= bus.serial_in;
          // Hold at the last index rather than wrapping.
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: par_mismatch <= (^shreg) ^ bus.serial_in;
        STOP: begin
          // A bad stop bit takes precedence over a parity failure.
          bus.frame_err  <= !stop_ok;
          bus.parity_err <= stop_ok && par_mismatch;
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

  frame_out_buffer #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (CLK),
    .rst        (RST),
    .load       (good_frame),
    .word       (shreg),
    .ready      (bus.data_ready),
    .data_out   (bus.data_out),
    .data_valid (bus.data_valid),
    .overrun    (bus.overrun)
  );

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module    : tb_serial_frame_deserializer
// Purpose   : Directed and randomized frames against a frame-level model.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deserializer;

  logic CLK;
  logic RST;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: the word the consumer currently sees.
  logic       m_valid;
  logic [7:0] m_out;

  serial_frame_deserializer_if #(.DATA_W(8)) bus ();

  serial_frame_deserializer #(.DATA_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // One clock edge: drive, clock, update model at frame level, compare.
  task automatic tick(input logic ser, input logic rdy, input logic is_stop,
                      input logic stop_bad, input logic par_bad,
                      input logic [7:0] word, input logic exp_busy);
    logic exp_p, exp_f, exp_o, good;
    bus.serial_in  = ser;
    bus.data_ready = rdy;
    @(posedge CLK);
    exp_p = 1'b0; exp_f = 1'b0; exp_o = 1'b0;
    good  = is_stop && !stop_bad && !par_bad;
    if (is_stop && stop_bad) exp_f = 1'b1;
    else if (is_stop && par_bad) exp_p = 1'b1;
    if (good && (!m_valid || rdy)) begin
      m_out   = word;
      m_valid = 1'b1;
    end else begin
      if (good) exp_o = 1'b1;
      else if (m_valid && rdy) m_valid = 1'b0;
    end
    #1;
    check("data_out",   32'(bus.data_out),   32'(m_out));
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("parity_err", 32'(bus.parity_err), 32'(exp_p));
    check("frame_err",  32'(bus.frame_err),  32'(exp_f));
    check("overrun",    32'(bus.overrun),    32'(exp_o));
    check("busy",       32'(bus.busy),       32'(exp_busy));
  endtask

  task automatic idle_tick(input logic rdy);
    tick(1'b0, rdy, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Whole frame: start, 8 data LSB first, parity (optionally wrong), stop.
  task automatic send_frame(input logic [7:0] word, input logic par_flip,
                            input logic stop_bit, input int rdy_mode,
                            input int stop_rdy_mode);
    logic pbit;
    pbit = (^word) ^ par_flip;
    tick(1'b1, pick_ready(rdy_mode), 1'b0, 1'b0, 1'b0, word, 1'b1);
    for (int i = 0; i < 8; i++)
      tick(word[i], pick_ready(rdy_mode), 1'b0, 1'b0, 1'b0, word, 1'b1);
    tick(pbit, pick_ready(rdy_mode), 1'b0, 1'b0, 1'b0, word, 1'b1);
    tick(stop_bit, pick_ready(stop_rdy_mode), 1'b1, stop_bit, par_flip, word, 1'b0);
  endtask

  task automatic check_quiet_reset(input string tag);
    check({tag, "_out"},   32'(bus.data_out),   32'h0);
    check({tag, "_valid"}, 32'(bus.data_valid), 32'h0);
    check({tag, "_perr"},  32'(bus.parity_err), 32'h0);
    check({tag, "_ferr"},  32'(bus.frame_err),  32'h0);
    check({tag, "_ovr"},   32'(bus.overrun),    32'h0);
    check({tag, "_busy"},  32'(bus.busy),       32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    bus.serial_in  = 1'b0;
    bus.data_ready = 1'b0;
    m_valid = 1'b0;
    m_out   = 8'h00;
    #2;
    check_quiet_reset("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Good frame 0xA5 with no consumer.
    idle_tick(1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
    check("a5_out",   32'(bus.data_out),   32'hA5);
    check("a5_valid", 32'(bus.data_valid), 32'h1);

    // One-edge ready pulse drains the buffer; word is held.
    idle_tick(1'b1);
    check("drain_valid", 32'(bus.data_valid), 32'h0);
    check("drain_out",   32'(bus.data_out),   32'hA5);

    // Parity error.
    send_frame(8'h3C, 1'b1, 1'b0, 0, 0);
    check("p3c_perr",  32'(bus.parity_err), 32'h1);
    check("p3c_valid", 32'(bus.data_valid), 32'h0);
    check("p3c_out",   32'(bus.data_out),   32'hA5);

    // Stop-bit error.
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    check("f81_ferr",  32'(bus.frame_err),  32'h1);
    check("f81_valid", 32'(bus.data_valid), 32'h0);

    // Back-to-back with full buffer: overrun.
    send_frame(8'h11, 1'b0, 1'b0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 0);
    check("b2b_out", 32'(bus.data_out), 32'h11);
    check("b2b_ovr", 32'(bus.overrun),  32'h1);
    idle_tick(1'b1);

    // Back-to-back with ready on the second stop edge.
    send_frame(8'h11, 1'b0, 1'b0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1);
    check("b2b_rdy_out", 32'(bus.data_out),   32'h22);
    check("b2b_rdy_ovr", 32'(bus.overrun),    32'h0);
    check("b2b_rdy_vld", 32'(bus.data_valid), 32'h1);

    // Mid-frame asynchronous reset after 4 data bits of 0xFF.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++)
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
    RST = 1'b1;
    #1;
    check_quiet_reset("midrst");
    m_valid = 1'b0;
    m_out   = 8'h00;
    bus.serial_in = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 0, 0);
    check("rst5a_out",  32'(bus.data_out),   32'h5A);
    check("rst5a_valid", 32'(bus.data_valid), 32'h1);

    // Randomized frames, errors, gaps and consumer behaviour.
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_tick(logic'($urandom_range(0, 1)));
      send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), 2, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
